// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
//
// Purpose: common definitions used by fetch_stage and fetch_fifo.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : addi x0, x0, 0 encoding loaded into IF/ID as a bubble
//   fetch_entry_t : one buffered fetch response, {pc, instr}
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO buffering fetch responses
//
// Purpose: small power-of-two FIFO of fetch_entry_t between imem and IF/ID.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (ignored while clear is high)
//   push_data  : entry to write
//   pop        : drop head entry (ignored when empty)
//   clear      : empty the FIFO; wins over push and pop
//   head       : current head entry (valid when !empty)
//   count      : number of stored entries
//   empty/full : status flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  assign do_pop  = pop & ~empty;
  // Full with a simultaneous pop still has room for the incoming entry.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  // The fetch credit scheme must never push into a full FIFO without a pop.
  always_ff @(posedge clk) begin
    if (!rst && !clear) begin
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I IF stage with response buffer and IF/ID register
//
// Purpose: issues sequential fetches over a valid/ready imem port with
// variable in-order response latency, buffers responses, and loads IF/ID.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (adds FetchMisalign_D).
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   En_F, En_D                    : fetch enable / IF/ID update enable
//   BrTaken_E, BrTarget_E         : EX redirect and its target
//   IMemReq_Valid/Ready/Addr      : imem request channel
//   IMemRsp_Valid/Data            : imem response channel
//   Instr_D, PC_D, PCPlus4_D      : IF/ID register contents
//   FetchMisalign_D               : (macro only) misaligned redirect marker
//   Valid_D                       : IF/ID holds a real instruction
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            En_F,
  input  logic            En_D,
  input  logic            BrTaken_E,
  input  logic [XLEN-1:0] BrTarget_E,
  output logic            IMemReq_Valid,
  input  logic            IMemReq_Ready,
  output logic [XLEN-1:0] IMemReq_Addr,
  input  logic            IMemRsp_Valid,
  input  logic [XLEN-1:0] IMemRsp_Data,
  output logic [XLEN-1:0] Instr_D,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PCPlus4_D,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic            FetchMisalign_D,
`endif
  output logic            Valid_D
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   in_flight_next;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            fifo_empty;
  logic            fifo_full;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_in;
  logic            accept;
  logic            rsp_drop;
  logic            rsp_push;
  logic            fifo_pop;
  logic            fetch_block;
  logic [XLEN-1:0] br_target;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_pend;
  logic misalign_sent;
  assign br_target   = BrTarget_E;
  assign fetch_block = misalign_pend;
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^BrTarget_E[1:0];
  assign br_target   = {BrTarget_E[XLEN-1:2], 2'b00};
  assign fetch_block = 1'b0;
`endif

  // Outstanding requests plus buffered entries never exceed the FIFO size,
  // so every response (unless dropped) is guaranteed a slot.
  assign credit_used   = {1'b0, in_flight} + {1'b0, fifo_count};
  assign IMemReq_Valid = ~rst & En_F & ~BrTaken_E & ~fetch_block & (credit_used < DEPTH_L);
  assign IMemReq_Addr  = pc;
  assign accept        = IMemReq_Valid & IMemReq_Ready;

  assign rsp_drop = IMemRsp_Valid & (drop != '0);
  assign rsp_push = IMemRsp_Valid & (drop == '0);
  assign in_flight_next = in_flight + CW'(accept) - CW'(IMemRsp_Valid);

  assign fifo_in  = '{pc: rsp_pc, instr: IMemRsp_Data};
  assign fifo_pop = En_D & ~fifo_empty & ~BrTaken_E;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .clear     (BrTaken_E),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      rsp_pc    <= RESET_PC;
      in_flight <= '0;
      drop      <= '0;
      Instr_D   <= NOP_INSTR;
      PC_D      <= '0;
      PCPlus4_D <= '0;
      Valid_D   <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_pend   <= 1'b0;
      misalign_sent   <= 1'b0;
      FetchMisalign_D <= 1'b0;
`endif
    end else begin
      in_flight <= in_flight_next;
      if (BrTaken_E) begin
        // Everything still owed by imem belongs to the wrong path.
        pc      <= br_target;
        rsp_pc  <= br_target;
        drop    <= in_flight_next;
        Instr_D <= NOP_INSTR;
        Valid_D <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_pend   <= |BrTarget_E[1:0];
        misalign_sent   <= 1'b0;
        FetchMisalign_D <= 1'b0;
`endif
      end else begin
        if (accept)   pc     <= pc + 32'd4;
        if (rsp_drop) drop   <= drop - 1'b1;
        if (rsp_push) rsp_pc <= rsp_pc + 32'd4;
        if (En_D) begin
          if (!fifo_empty) begin
            Instr_D   <= fifo_head.instr;
            PC_D      <= fifo_head.pc;
            PCPlus4_D <= fifo_head.pc + 32'd4;
            Valid_D   <= 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
          end else if (misalign_pend && !misalign_sent) begin
            // pc still holds the misaligned target: nothing was issued since.
            Instr_D         <= NOP_INSTR;
            PC_D            <= pc;
            PCPlus4_D       <= pc + 32'd4;
            Valid_D         <= 1'b1;
            FetchMisalign_D <= 1'b1;
            misalign_sent   <= 1'b1;
`endif
          end else begin
            Instr_D <= NOP_INSTR;
            Valid_D <= 1'b0;
          end
        end
      end
    end
  end

endmodule
